// File: rtl/mp_add_seq.sv
// rtl/mp_add_seq.sv - word-serial multi-precision adder with carry chained across words
// Optional signed-overflow output enabled by defining MP_ADD_SEQ_OVF_EN.

module mp_add_seq_rca #(
    parameter int BITWIDTH = 8
) (
    input  logic [BITWIDTH-1:0] a,
    input  logic [BITWIDTH-1:0] b,
    input  logic                ci,
    output logic [BITWIDTH-1:0] sum,
`ifdef MP_ADD_SEQ_OVF_EN
    output logic                c_msb,
`endif
    output logic                co
);
    logic [BITWIDTH:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < BITWIDTH; i++) begin : g_fa
        assign sum[i] = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

`ifdef MP_ADD_SEQ_OVF_EN
    assign c_msb = c[BITWIDTH-1];
`endif
    assign co = c[BITWIDTH];
endmodule

module mp_add_seq #(
    parameter int BITWIDTH = 8,
    parameter int WORDS    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] in_a,
    input  logic [BITWIDTH-1:0] in_b,
    input  logic                cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] out_sum,
    output logic                out_last,
`ifdef MP_ADD_SEQ_OVF_EN
    output logic                out_ovf,
`endif
    output logic                out_cout
);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]          state;
    logic [IDX_W-1:0]    idx;
    logic                cy;

    logic                accept;
    logic                is_last;
    logic                carry_in;
    logic [BITWIDTH-1:0] sum;
    logic                carry_next;
`ifdef MP_ADD_SEQ_OVF_EN
    logic                carry_msb;
`endif

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign is_last  = (idx == LAST_IDX);
    // The first word of an operation takes the external carry; later words chain cy.
    assign carry_in = (state == ST_IDLE) ? cin : cy;

    mp_add_seq_rca #(
        .BITWIDTH(BITWIDTH)
    ) u_rca (
        .a    (in_a),
        .b    (in_b),
        .ci   (carry_in),
        .sum  (sum),
`ifdef MP_ADD_SEQ_OVF_EN
        .c_msb(carry_msb),
`endif
        .co   (carry_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            cy        <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
`ifdef MP_ADD_SEQ_OVF_EN
            out_ovf   <= 1'b0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sum   <= sum;
            out_last  <= is_last;
            out_cout  <= is_last ? carry_next : 1'b0;
`ifdef MP_ADD_SEQ_OVF_EN
            out_ovf   <= is_last ? (carry_msb ^ carry_next) : 1'b0;
`endif
            // Clearing cy on the last word keeps the next operation from inheriting it.
            cy        <= is_last ? 1'b0 : carry_next;
            idx       <= is_last ? '0 : idx + 1'b1;
            state     <= is_last ? ST_IDLE : ST_BUSY;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mp_add_seq.sv
// tb/tb_mp_add_seq.sv - scoreboard bench for mp_add_seq (BITWIDTH=8, WORDS=4)

module tb_mp_add_seq;
    localparam int BW = 8;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_a = '0;
    logic [BW-1:0] in_b = '0;
    logic          cin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [BW-1:0] out_sum;
    logic          out_last;
    logic          out_cout;
    logic          ovf_bit;
`ifdef MP_ADD_SEQ_OVF_EN
    logic          out_ovf;
    assign ovf_bit = out_ovf;
`else
    assign ovf_bit = 1'b0;
`endif

    mp_add_seq #(.BITWIDTH(BW), .WORDS(NW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_last (out_last),
`ifdef MP_ADD_SEQ_OVF_EN
        .out_ovf  (out_ovf),
`endif
        .out_cout (out_cout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BW-1:0] sum;
        logic          last;
        logic          cout;
        logic          ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // Reference: whole-operand arithmetic, then split into words.
    task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic c);
        logic [32:0] full;
        exp_t e;
        full = {1'b0, a} + {1'b0, b} + {32'd0, c};
        for (int i = 0; i < NW; i++) begin
            e.sum  = full[8*i +: 8];
            e.last = (i == NW - 1);
            e.cout = e.last ? full[32] : 1'b0;
            e.ovf  = 1'b0;
`ifdef MP_ADD_SEQ_OVF_EN
            e.ovf  = e.last ? ((a[31] == b[31]) && (full[31] != a[31])) : 1'b0;
`endif
            sb.push_back(e);
        end
    endtask

    // Monitor: every output handshake pops one expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got sum=0x%0h with empty scoreboard", out_sum);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_word{sum,last,cout,ovf}",
                      {53'd0, out_sum, out_last, out_cout, ovf_bit},
                      {53'd0, e.sum, e.last, e.cout, e.ovf});
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send_word(input logic [7:0] wa, input logic [7:0] wb, input logic wc);
        bit acc;
        int n;
        in_a = wa;
        in_b = wb;
        cin = wc;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got no accept, expected accept within 1000 cycles");
        end
    endtask

    task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic c, input bit gaps);
        push_op(a, b, c);
        for (int i = 0; i < NW; i++) begin
            send_word(a[8*i +: 8], b[8*i +: 8], (i == 0) ? c : 1'($urandom));
            if (gaps) repeat ($urandom_range(0, 2)) begin
                in_a = 8'($urandom);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d words pending, expected 0", sb.size());
        end
    endtask

    initial begin
        int c0;
        logic [31:0] ra, rb;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_sum", out_sum, 0);
        check("reset_out_last", out_last, 0);
        check("reset_out_cout", out_cout, 0);
        check("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Carry ripple through every word
        send_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_drain();

        // Carry-in used only on the first word
        send_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        wait_drain();

        // Backpressure: stall downstream for 3 cycles after the first word
        push_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        send_word(8'hFF, 8'h01, 1'b0);
        out_ready = 1'b0;
        in_a = 8'hFF;
        in_b = 8'h00;
        cin = 1'b1;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_sum", out_sum, 8'h00);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int i = 1; i < NW; i++) send_word(8'hFF, 8'h00, 1'b1);
        wait_drain();

        // Back-to-back operations: no idle cycle, no inherited carry
        c0 = cyc;
        send_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        send_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        check("back_to_back_cycles", 64'(cyc - c0), 2 * NW);
        wait_drain();

        // Reset mid-operation after 2 words
        begin
            logic [32:0] part;
            exp_t e;
            part = 33'h0_AABB_CCDD + 33'h0_1122_3344;
            for (int i = 0; i < 2; i++) begin
                e.sum = part[8*i +: 8];
                e.last = 1'b0;
                e.cout = 1'b0;
                e.ovf = 1'b0;
                sb.push_back(e);
            end
            send_word(8'hDD, 8'h44, 1'b0);
            send_word(8'hCC, 8'h33, 1'b1);
            @(negedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            check("midreset_out_valid", out_valid, 0);
            check("midreset_in_ready", in_ready, 1);
            check("midreset_sb_empty", 64'(sb.size()), 0);
            @(posedge clk);
            @(negedge clk);
            check("midreset_out_valid_held", out_valid, 0);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk);
            #1;
        end
        send_op(32'h0102_0304, 32'h0101_0101, 1'b0, 1'b0);
        wait_drain();

`ifdef MP_ADD_SEQ_OVF_EN
        send_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_drain();
`endif

        // Randomized operations with random gaps and random backpressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            rb = $urandom;
            if (k % 8 == 0) rb = ~ra;
            send_op(ra, rb, 1'($urandom), 1'b1);
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        check("final_sb_empty", 64'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
